// File: rtl/sprite_rom_pkg.sv
// Shared parameters, requester IDs and types for the sprite ROM port scheduler.
package sprite_rom_pkg;

  localparam int N_REQ     = 4;
  localparam int ADDR_W    = 20;
  localparam int DATA_W    = 8;
  localparam int LEN_W     = 6;
  localparam int ROM_LAT   = 1;
  localparam int REQ_IDX_W = $clog2(N_REQ);

  localparam int REQ_KIRBY   = 0;
  localparam int REQ_ENEMY   = 1;
  localparam int REQ_ATK     = 2;
  localparam int REQ_BOSSATK = 3;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } sched_state_t;

  // Metadata travelling alongside each issued ROM address.
  typedef struct packed {
    logic                 valid;
    logic [REQ_IDX_W-1:0] owner;
    logic                 last;
  } beat_tag_t;

endpackage

// File: rtl/sprite_rom_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: search starts just after ptr and wraps.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt
);

  // N is a power of two, so the index wraps naturally in IDX_W bits.
  always_comb begin
    logic             found;
    logic [IDX_W-1:0] idx;
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= N; i++) begin
      idx = ptr + i[IDX_W-1:0];
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sprite_rom_scheduler.sv
// Round-robin burst scheduler for one shared registered-read sprite ROM port.
// Handshake: a burst is accepted at a clock edge where req[i] & gnt[i] is high;
// gnt is only offered in IDLE, and req_addr/req_len are sampled only at that edge.
module sprite_rom_scheduler
  import sprite_rom_pkg::*;
(
  input  logic                            Clk,
  input  logic                            Reset_n,
  input  logic [N_REQ-1:0]                req,
  input  logic [N_REQ-1:0][ADDR_W-1:0]    req_addr,
  input  logic [N_REQ-1:0][LEN_W-1:0]     req_len,
  output logic [N_REQ-1:0]                gnt,
  output logic                            busy,
  output logic [ADDR_W-1:0]               rom_addr,
  input  logic [DATA_W-1:0]               rom_data,
  output logic [N_REQ-1:0]                rvalid,
  output logic                            rlast,
  output logic [DATA_W-1:0]               rdata,
  output sched_state_t                    state_dbg
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_BURST = 1'b1;

  logic [0:0]               state_q, state_d;
  logic [ADDR_W-1:0]        rom_addr_q, rom_addr_d;
  logic [LEN_W-1:0]         cnt_q, cnt_d;
  logic [REQ_IDX_W-1:0]     owner_q, owner_d;
  logic [REQ_IDX_W-1:0]     ptr_q, ptr_d;
  beat_tag_t [ROM_LAT:0]    pipe_q, pipe_d;
  logic [N_REQ-1:0]         rvalid_q, rvalid_d;
  logic                     rlast_q, rlast_d;
  logic [DATA_W-1:0]        rdata_q, rdata_d;

  logic [N_REQ-1:0]         arb_gnt;
  logic [REQ_IDX_W-1:0]     win;
  logic                     accept;
  beat_tag_t                issue;
  beat_tag_t                emerge;

  rr_arbiter #(.N(N_REQ), .IDX_W(REQ_IDX_W)) u_arb (
    .req (req),
    .ptr (ptr_q),
    .gnt (arb_gnt)
  );

  // Grant is suppressed during a burst and while reset is asserted.
  assign gnt    = (state_q == S_IDLE && Reset_n) ? arb_gnt : '0;
  assign accept = |gnt;

  always_comb begin
    win = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (arb_gnt[i]) win = i[REQ_IDX_W-1:0];
    end
  end

  always_comb begin
    state_d    = state_q;
    rom_addr_d = rom_addr_q;
    cnt_d      = cnt_q;
    owner_d    = owner_q;
    ptr_d      = ptr_q;
    issue      = '0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          rom_addr_d  = req_addr[win];
          cnt_d       = req_len[win];
          owner_d     = win;
          ptr_d       = win;
          issue.valid = 1'b1;
          issue.owner = win;
          issue.last  = (req_len[win] == '0);
          state_d     = (req_len[win] != '0) ? S_BURST : S_IDLE;
        end
      end
      default: begin
        rom_addr_d  = rom_addr_q + ADDR_W'(1);
        cnt_d       = cnt_q - LEN_W'(1);
        issue.valid = 1'b1;
        issue.owner = owner_q;
        issue.last  = (cnt_q == LEN_W'(1));
        if (cnt_q == LEN_W'(1)) state_d = S_IDLE;
      end
    endcase
  end

  // Tags trail the ROM by ROM_LAT+1 edges so they meet the matching data.
  always_comb begin
    pipe_d  = {pipe_q[ROM_LAT-1:0], issue};
    emerge  = pipe_q[ROM_LAT];
    rlast_d = emerge.valid & emerge.last;
    rdata_d = emerge.valid ? rom_data : rdata_q;
    for (int i = 0; i < N_REQ; i++) begin
      rvalid_d[i] = emerge.valid && (emerge.owner == i[REQ_IDX_W-1:0]);
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= S_IDLE;
      rom_addr_q <= '0;
      cnt_q      <= '0;
      owner_q    <= '0;
      ptr_q      <= REQ_IDX_W'(N_REQ - 1);
      pipe_q     <= '0;
      rvalid_q   <= '0;
      rlast_q    <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      rom_addr_q <= rom_addr_d;
      cnt_q      <= cnt_d;
      owner_q    <= owner_d;
      ptr_q      <= ptr_d;
      pipe_q     <= pipe_d;
      rvalid_q   <= rvalid_d;
      rlast_q    <= rlast_d;
      rdata_q    <= rdata_d;
    end
  end

  assign busy      = (state_q == S_BURST);
  assign rom_addr  = rom_addr_q;
  assign rvalid    = rvalid_q;
  assign rlast     = rlast_q;
  assign rdata     = rdata_q;
  assign state_dbg = sched_state_t'(state_q);

endmodule

// File: tb/tb_sprite_rom_scheduler.sv
// Bench for sprite_rom_scheduler: directed scenarios plus random traffic against
// a cycle-schedule reference model of the shared ROM port.
module tb_sprite_rom_scheduler;
  import sprite_rom_pkg::*;

  // ---------------- clock / reset ----------------
  logic                         Clk = 1'b0;
  logic                         Reset_n = 1'b0;
  logic [N_REQ-1:0]             req;
  logic [N_REQ-1:0][ADDR_W-1:0] req_addr;
  logic [N_REQ-1:0][LEN_W-1:0]  req_len;
  logic [N_REQ-1:0]             gnt;
  logic                         busy;
  logic [ADDR_W-1:0]            rom_addr;
  logic [DATA_W-1:0]            rom_data;
  logic [N_REQ-1:0]             rvalid;
  logic                         rlast;
  logic [DATA_W-1:0]            rdata;
  sched_state_t                 state_dbg;

  always #5 Clk = ~Clk;

  sprite_rom_scheduler dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .req       (req),
    .req_addr  (req_addr),
    .req_len   (req_len),
    .gnt       (gnt),
    .busy      (busy),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .rvalid    (rvalid),
    .rlast     (rlast),
    .rdata     (rdata),
    .state_dbg (state_dbg)
  );

  // ROM contents are a keyed hash of the address; one-cycle registered read.
  logic [7:0] rom_key;

  function automatic logic [DATA_W-1:0] rom_fn(input logic [ADDR_W-1:0] a);
    return a[7:0] ^ {a[11:8], a[15:12]} ^ {4'h0, a[19:16]} ^ rom_key;
  endfunction

  always @(posedge Clk) rom_data <= rom_fn(rom_addr);

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic int rr_pick(input logic [N_REQ-1:0] r, input int p);
    for (int i = 1; i <= N_REQ; i++) begin
      int idx = (p + i) % N_REQ;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  // ---------------- scoreboard / reference model ----------------
  // exp_q entry: {due cycle[15:0], owner[1:0], last, addr[19:0]}
  logic [38:0]       exp_q[$];
  int                addr_exp[int];
  int                obs_log[$];
  int                cyc     = 0;
  int                ptr_m   = N_REQ - 1;
  int                free_at = 0;
  int                busy_lo = 1;
  int                busy_hi = 0;
  logic [DATA_W-1:0] rdata_m = '0;

  always @(negedge Clk) begin : mon
    int                w;
    int                len;
    logic [N_REQ-1:0]  eg;
    logic [N_REQ-1:0]  ev;
    logic [38:0]       e;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] a;
    if (!Reset_n) begin
      exp_q.delete();
      addr_exp.delete();
      ptr_m   = N_REQ - 1;
      free_at = 0;
      busy_lo = 1;
      busy_hi = 0;
      rdata_m = '0;
      chk("rst_gnt", gnt, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rom_addr", rom_addr, 0);
      chk("rst_rvalid", rvalid, 0);
      chk("rst_rlast", rlast, 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_state", state_dbg, IDLE);
    end else begin
      for (int i = 0; i < N_REQ; i++) if (gnt[i] && req[i]) obs_log.push_back(i);
      eg = '0;
      w  = (cyc >= free_at) ? rr_pick(req, ptr_m) : -1;
      if (w >= 0) eg[w] = 1'b1;
      chk("gnt", gnt, eg);
      chk("busy", busy, (cyc >= busy_lo && cyc <= busy_hi));
      if (addr_exp.exists(cyc)) chk("rom_addr", rom_addr, addr_exp[cyc]);
      if (exp_q.size() > 0 && int'(exp_q[0][38:23]) == (cyc & 16'hFFFF)) begin
        e       = exp_q.pop_front();
        ev      = '0;
        ev[e[22:21]] = 1'b1;
        rdata_m = rom_fn(e[19:0]);
        chk("rvalid", rvalid, ev);
        chk("rlast", rlast, e[20]);
        chk("rdata", rdata, rdata_m);
      end else begin
        chk("rvalid_idle", rvalid, 0);
        chk("rlast_idle", rlast, 0);
        chk("rdata_hold", rdata, rdata_m);
      end
      if (w >= 0) begin
        len  = int'(req_len[w]) + 1;
        base = req_addr[w];
        for (int k = 0; k < len; k++) begin
          a = base + ADDR_W'(k);
          addr_exp[cyc + 1 + k] = int'(a);
          exp_q.push_back({16'(cyc + 3 + k), 2'(w), (k == len - 1), a});
        end
        free_at = cyc + len;
        busy_lo = cyc + 1;
        busy_hi = cyc + len - 1;
        ptr_m   = w;
      end
    end
    cyc++;
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] l);
    req[i]      = 1'b1;
    req_addr[i] = a;
    req_len[i]  = l;
  endtask

  task automatic wait_gnt(input int i, input string tag, output int n);
    bit got = 1'b0;
    n = 0;
    while (!got && n < 300) begin
      @(negedge Clk);
      n++;
      got = req[i] & gnt[i];
    end
    chk(tag, got, 1);
  endtask

  function automatic int log_at(input int k);
    return (k < obs_log.size()) ? obs_log[k] : -1;
  endfunction

  function automatic logic [ADDR_W-1:0] rand_addr();
    if ($urandom_range(0, 7) == 0) return 20'hFFFF0 + ADDR_W'($urandom_range(0, 15));
    return ADDR_W'($urandom);
  endfunction

  function automatic logic [LEN_W-1:0] rand_len();
    if ($urandom_range(0, 15) == 0) return 6'd63;
    return LEN_W'($urandom_range(0, 7));
  endfunction

  // ---------------- directed + random sequence ----------------
  initial begin
    int               n;
    logic [N_REQ-1:0] acc;
    logic [ADDR_W-1:0] wrap_exp[4];
    wrap_exp = '{20'hFFFFE, 20'hFFFFF, 20'h00000, 20'h00001};
    rom_key  = 8'($urandom);
    req      = '0;
    req_addr = '0;
    req_len  = '0;
    Reset_n  = 1'b0;
    repeat (3) step();
    Reset_n = 1'b1;
    step();

    // single burst on requester 1
    set_req(REQ_ENEMY, 20'h00100, 6'd3);
    wait_gnt(REQ_ENEMY, "single_gnt", n);
    step();
    req[REQ_ENEMY] = 1'b0;
    repeat (8) step();

    // fairness: 2 held, 0 arrives during 2's burst
    obs_log.delete();
    set_req(REQ_ATK, rand_addr(), 6'd3);
    wait_gnt(REQ_ATK, "fair_gnt2a", n);
    step();
    set_req(REQ_KIRBY, rand_addr(), 6'd0);
    wait_gnt(REQ_KIRBY, "fair_gnt0", n);
    step();
    req[REQ_KIRBY] = 1'b0;
    wait_gnt(REQ_ATK, "fair_gnt2b", n);
    step();
    req[REQ_ATK] = 1'b0;
    chk("fair_order0", log_at(0), 2);
    chk("fair_order1", log_at(1), 0);
    chk("fair_order2", log_at(2), 2);
    repeat (8) step();

    // address wrap
    set_req(REQ_ENEMY, 20'hFFFFE, 6'd3);
    wait_gnt(REQ_ENEMY, "wrap_gnt", n);
    step();
    req[REQ_ENEMY] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("wrap_addr", rom_addr, wrap_exp[k]);
      step();
    end
    repeat (6) step();

    // back-to-back: 64-beat burst then immediate grant to 0
    set_req(REQ_BOSSATK, rand_addr(), 6'd63);
    wait_gnt(REQ_BOSSATK, "b2b_gnt3", n);
    step();
    req[REQ_BOSSATK] = 1'b0;
    set_req(REQ_KIRBY, rand_addr(), 6'd0);
    wait_gnt(REQ_KIRBY, "b2b_gnt0", n);
    chk("b2b_gap", n, 64);
    step();
    req[REQ_KIRBY] = 1'b0;
    repeat (6) step();

    // reset mid-burst with a request held, then 4-way contention
    set_req(REQ_ATK, rand_addr(), 6'd20);
    wait_gnt(REQ_ATK, "rst_burst_gnt", n);
    step();
    repeat (4) step();
    Reset_n = 1'b0;
    #1;
    chk("rst_gnt_async", gnt, 0);
    chk("rst_busy_async", busy, 0);
    repeat (3) step();
    obs_log.delete();
    for (int i = 0; i < N_REQ; i++) set_req(i, rand_addr(), 6'd0);
    Reset_n = 1'b1;
    repeat (5) step();
    req = '0;
    chk("cont_order0", log_at(0), 0);
    chk("cont_order1", log_at(1), 1);
    chk("cont_order2", log_at(2), 2);
    chk("cont_order3", log_at(3), 3);
    chk("cont_order4", log_at(4), 0);
    repeat (6) step();

    // random traffic: granted requesters drop or re-request
    repeat (400) begin
      @(negedge Clk);
      acc = gnt & req;
      @(posedge Clk);
      #1;
      for (int i = 0; i < N_REQ; i++) begin
        if (acc[i]) begin
          if ($urandom_range(0, 3) == 0) set_req(i, rand_addr(), rand_len());
          else req[i] = 1'b0;
        end else if (!req[i]) begin
          if ($urandom_range(0, 3) == 0) set_req(i, rand_addr(), rand_len());
        end else if ($urandom_range(0, 15) == 0) begin
          req[i] = 1'b0;
        end
      end
    end
    req = '0;

    n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      step();
      n++;
    end
    chk("drain", exp_q.size(), 0);
    repeat (2) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sprite_rom_scheduler.md
# sprite_rom_scheduler

Shares one registered-read sprite ROM port (20-bit address, 8-bit data, 1-cycle latency) among several sprite-drawing engines (Kirby, enemy, attack, boss attack). Each requester asks for a burst of consecutive texels (one sprite row segment). The scheduler grants round-robin, issues one ROM address per cycle for the winning burst, and returns tagged read data. It sits between the per-sprite draw FSMs and the ROM instance feeding the frame composer.

## Interface
- N_REQ, 4, number of requesters
- ADDR_W, 20, ROM address width
- DATA_W, 8, texel width
- LEN_W, 6, burst length field width (beats-1, so 1..64 beats)
- ROM_LAT, 1, ROM read latency in clocks (address register edge to data-valid edge)
- Clk  in  1  single clock, all logic on posedge
- Reset_n  in  1  asynchronous, active-low reset
- req  in  N_REQ  burst request, level, per requester
- req_addr  in  N_REQ x ADDR_W  burst base address
- req_len  in  N_REQ x LEN_W  beats minus one
- gnt  out  N_REQ  combinational one-hot accept; transfer occurs at an edge where req[i] & gnt[i]
- busy  out  1  burst in progress (state BURST)
- rom_addr  out  ADDR_W  to ROM R_ADDR
- rom_data  in  DATA_W  from ROM data_Out
- rvalid  out  N_REQ  one-hot, read data valid for requester i
- rlast  out  1  final beat of a burst
- rdata  out  DATA_W  returned texel

## Operation
- States: IDLE, BURST.
- IDLE: if any req, gnt the round-robin winner (at most one bit set). At the accept edge: rom_addr <= req_addr[w], beat counter <= req_len[w], owner <= w, last-granted pointer <= w. Go to BURST if req_len[w] != 0, else stay IDLE.
- BURST: gnt = 0. Each edge: rom_addr <= rom_addr + 1 (modulo 2^ADDR_W, wraps 0xFFFFF -> 0x00000) and counter decrements. The edge that issues the final beat (counter == 1 before decrement) returns to IDLE.
- Round-robin: search starts at pointer+1 and wraps. After reset, pointer = N_REQ-1, so requester 0 has first priority.
- Return pipeline: shift register of depth ROM_LAT+1 carries {valid, owner, last} alongside each issued address. When it emerges: rvalid[owner] <= 1, rlast <= last, rdata <= rom_data. Otherwise rvalid <= 0 and rlast <= 0; rdata holds.
- Dropping req mid-burst has no effect; the burst completes. req_addr and req_len are sampled only at the accept edge.

## Timing
- Reset (async assert, sync-safe release): state IDLE, rom_addr 0, pointer N_REQ-1, pipeline cleared, rvalid 0, rlast 0, rdata 0, busy 0. In-flight beats are discarded. gnt is 0 while Reset_n is low.
- Accept at edge E issues beat 0. Beat k is issued at edge E+k. Beat k returns with rvalid high in the cycle after edge E+k+ROM_LAT+1 (3rd cycle after accept for ROM_LAT=1).
- An L-beat burst occupies the port for exactly L cycles. The next grant happens in the cycle after the final issue edge (IDLE), with no bubble.
- Simultaneous requests: exactly one granted. A requester holding req wins again only after all other pending requesters have been served.
- Throughput: 1 beat per cycle sustained. rvalid pulses are contiguous within a burst.

## Structure
- Shared package sprite_rom_pkg: N_REQ, ADDR_W, DATA_W, LEN_W, requester IDs (REQ_KIRBY=0, REQ_ENEMY=1, REQ_ATK=2, REQ_BOSSATK=3), state enum sched_state_t {IDLE, BURST}.
- Sub-module rr_arbiter (N_REQ-wide, pointer in, one-hot grant out, combinational). The pointer register stays in the scheduler.

## Test plan
- Reset: hold Reset_n low mid-burst, release -> all outputs 0, pointer restarts, requester 0 wins the first grant.
- Single burst: req[1], addr 0x00100, len 3 -> rom_addr 0x100..0x103 on 4 consecutive cycles; rvalid[1] for 4 cycles starting 3 cycles after accept, rlast on the 4th, rdata matches ROM model.
- Contention: req[0..3] all high with len 0 -> grants in order 0,1,2,3,0; each returns 1 beat tagged to the correct rvalid bit.
- Fairness: req[2] held continuously, req[0] asserted during 2's burst -> 0 granted next, before 2 again.
- Wrap: addr 0xFFFFE, len 3 -> addresses 0xFFFFE, 0xFFFFF, 0x00000, 0x00001.
- Back-to-back: req[3] len 63 then req[0] pending -> 64 consecutive beats, then 0 granted on the very next cycle, with no gap in rom_addr activity.
